// File: rtl/instr_uart_loader_pkg.sv
// Types and constants for the UART instruction loader; markers and image size come from cpu_define.
`include "cpu_define.sv"

package instr_uart_loader_pkg;

    localparam logic [7:0] INSTR_START_B  = `INSTR_START;
    localparam logic [7:0] INSTR_END_B    = `INSTR_END;
    localparam int         LOAD_BYTES_DEF = `INSTR_MEM_NUM * 4;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_RECV,
        LD_START,
        LD_BURST,
        LD_END,
        LD_DONE
    } ld_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PAR,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/instr_uart_loader_if.sv
// Serial input and instruction-stream/status outputs of the loader; slave = loader, master = environment.
interface instr_uart_loader_if;
    logic       uart_rx_i;
    logic [7:0] instr_o;
    logic       cpu_hold_o;
    logic       load_done_o;
    logic       frame_err_o;

    modport slave  (input  uart_rx_i, output instr_o, cpu_hold_o, load_done_o, frame_err_o);
    modport master (output uart_rx_i, input  instr_o, cpu_hold_o, load_done_o, frame_err_o);
endinterface

// File: rtl/cpu_define.sv
// Shared CPU-wide constants: instruction-memory depth and loader framing markers.
`ifndef CPU_DEFINE_SV
`define CPU_DEFINE_SV
`define INSTR_MEM_NUM 64
`define INSTR_START   8'hF0
`define INSTR_END     8'h0F
`endif

// File: rtl/uart_rx.sv
// UART byte receiver (8N1, or 8E1 with LOADER_PARITY_EN); 2-flop synchronized input, mid-bit sampling.
// Latency: rx_valid/rx_err pulse one cycle at the stop-bit sample; no backpressure, bytes are never held.
module uart_rx
    import instr_uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       sys_clk,
    input  logic       sys_reset,
    input  logic       rx_serial_i,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_err,
    output logic       rx_start
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [1:0]       sync_q;
    logic             rxd_prev_q;
    logic             rxd;
    logic             stop_ok;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;

    assign rxd     = sync_q[1];
    assign rx_data = shift_q;

    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            sync_q     <= 2'b11;
            rxd_prev_q <= 1'b1;
            state_q    <= RX_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
        end else begin
            sync_q     <= {sync_q[0], rx_serial_i};
            rxd_prev_q <= rxd;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
        end
    end

`ifdef LOADER_PARITY_EN
    logic par_bad_q, par_bad_d;

    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) par_bad_q <= 1'b0;
        else           par_bad_q <= par_bad_d;
    end

    // A parity mismatch is folded into the stop check so it reports as a frame error.
    assign stop_ok = rxd & ~par_bad_q;
`else
    assign stop_ok = rxd;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        rx_valid = 1'b0;
        rx_err   = 1'b0;
        rx_start = 1'b0;
`ifdef LOADER_PARITY_EN
        par_bad_d = par_bad_q;
`endif
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                // Edge, not level: a line left low by a bad stop bit must not retrigger.
                if (rxd_prev_q && !rxd) state_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!rxd) begin
                        state_d  = RX_DATA;
                        bit_d    = '0;
                        rx_start = 1'b1;
                    end else begin
                        state_d = RX_IDLE;
                    end
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rxd, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
`ifdef LOADER_PARITY_EN
                        state_d = RX_PAR;
`else
                        state_d = RX_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
`ifdef LOADER_PARITY_EN
            RX_PAR: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = '0;
                    par_bad_d = rxd ^ (^shift_q);
                    state_d   = RX_STOP;
                end
            end
`endif
            RX_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d    = '0;
                    state_d  = RX_IDLE;
                    rx_valid = stop_ok;
                    rx_err   = ~stop_ok;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/instr_uart_loader.sv
// Collects a LOAD_BYTES program image over UART and bursts START/image/END into instruction memory (LOADER_PARITY_EN selects 8E1).
// Latency: burst starts two cycles after the last byte's stop sample; no backpressure, the burst is free-running.
module instr_uart_loader
    import instr_uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int LOAD_BYTES   = LOAD_BYTES_DEF
) (
    input  logic               sys_clk,
    input  logic               sys_reset,
    instr_uart_loader_if.slave bus
);
    localparam int PTR_W  = $clog2(LOAD_BYTES + 1);
    localparam int ADDR_W = (LOAD_BYTES > 1) ? $clog2(LOAD_BYTES) : 1;
    localparam logic [PTR_W-1:0]  PTR_FULL = PTR_W'(LOAD_BYTES);
    localparam logic [ADDR_W-1:0] RD_LAST  = ADDR_W'(LOAD_BYTES - 1);

    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_err;
    logic              rx_start;

    ld_state_e         state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic              frame_err_q, frame_err_d;
    logic              wr_en;
    logic [7:0]        instr;
    logic              cpu_hold;
    logic              load_done;
    logic [7:0]        mem_q [LOAD_BYTES];

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_rx (
        .sys_clk    (sys_clk),
        .sys_reset  (sys_reset),
        .rx_serial_i(bus.uart_rx_i),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_err     (rx_err),
        .rx_start   (rx_start)
    );

    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            state_q     <= LD_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Image storage is not reset; the write pointer alone defines what is valid.
    always_ff @(posedge sys_clk) begin
        if (wr_en) mem_q[wr_ptr_q[ADDR_W-1:0]] <= rx_data;
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        frame_err_d = frame_err_q | rx_err;
        wr_en       = 1'b0;
        instr       = 8'h00;
        cpu_hold    = 1'b0;
        load_done   = 1'b0;
        case (state_q)
            LD_IDLE: begin
                if (rx_start) state_d = LD_RECV;
            end
            LD_RECV: begin
                cpu_hold = 1'b1;
                if (wr_ptr_q == PTR_FULL) begin
                    state_d = LD_START;
                end else if (rx_valid) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                end
            end
            LD_START: begin
                cpu_hold = 1'b1;
                instr    = INSTR_START_B;
                rd_ptr_d = '0;
                state_d  = LD_BURST;
            end
            LD_BURST: begin
                cpu_hold = 1'b1;
                instr    = mem_q[rd_ptr_q];
                rd_ptr_d = rd_ptr_q + 1'b1;
                if (rd_ptr_q == RD_LAST) state_d = LD_END;
            end
            LD_END: begin
                cpu_hold = 1'b1;
                instr    = INSTR_END_B;
                state_d  = LD_DONE;
            end
            LD_DONE: begin
                load_done = 1'b1;
            end
            default: state_d = LD_IDLE;
        endcase
    end

    assign bus.instr_o     = instr;
    assign bus.cpu_hold_o  = cpu_hold;
    assign bus.load_done_o = load_done;
    assign bus.frame_err_o = frame_err_q;

endmodule

// File: tb/tb_instr_uart_loader.sv
// Scoreboard bench: an 8-byte-image loader and a default-size loader, random UART traffic, image-level reference model.
module tb_instr_uart_loader;
    import instr_uart_loader_pkg::*;

    localparam int CPB  = 16;
    localparam int L8   = 8;
    localparam int L256 = LOAD_BYTES_DEF;

    logic sys_clk   = 1'b0;
    logic sys_reset = 1'b1;
    logic rx8       = 1'b1;
    logic rx256     = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] sb8[$];
    logic [7:0] sb256[$];
    logic [7:0] img8[$];
    logic [7:0] img256[$];
    bit         done_m [2];
    bit         ferr_m [2];
    int         win8   = 0;
    int         win256 = 0;

    always #5 sys_clk = ~sys_clk;

    instr_uart_loader_if bus8 ();
    instr_uart_loader_if bus256 ();
    assign bus8.uart_rx_i   = rx8;
    assign bus256.uart_rx_i = rx256;

    instr_uart_loader #(.CLKS_PER_BIT(CPB), .LOAD_BYTES(L8)) dut8 (
        .sys_clk  (sys_clk),
        .sys_reset(sys_reset),
        .bus      (bus8)
    );

    instr_uart_loader #(.CLKS_PER_BIT(CPB)) dut256 (
        .sys_clk  (sys_clk),
        .sys_reset(sys_reset),
        .bus      (bus256)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic set_line(input int w, input logic v);
        if (w == 0) rx8 = v;
        else        rx256 = v;
    endtask

    // {instr[7:0], hold, done, ferr}
    function automatic logic [10:0] outs(input int w);
        if (w == 0) return {bus8.instr_o, bus8.cpu_hold_o, bus8.load_done_o, bus8.frame_err_o};
        return {bus256.instr_o, bus256.cpu_hold_o, bus256.load_done_o, bus256.frame_err_o};
    endfunction

    task automatic model_reset();
        img8.delete();
        img256.delete();
        sb8.delete();
        sb256.delete();
        for (int i = 0; i < 2; i++) begin
            done_m[i] = 1'b0;
            ferr_m[i] = 1'b0;
        end
    endtask

    // Image-level model: good bytes accumulate until the image is full, then the whole
    // START / image / END sequence becomes the expected output; after that everything is ignored.
    task automatic model_issue(input int w, input logic [7:0] b, input bit good);
        if (!good) ferr_m[w] = 1'b1;
        if (done_m[w] || !good) return;
        if (w == 0) begin
            img8.push_back(b);
            if (img8.size() == L8) begin
                sb8.push_back(INSTR_START_B);
                foreach (img8[i]) sb8.push_back(img8[i]);
                sb8.push_back(INSTR_END_B);
                img8.delete();
                done_m[0] = 1'b1;
            end
        end else begin
            img256.push_back(b);
            if (img256.size() == L256) begin
                sb256.push_back(INSTR_START_B);
                foreach (img256[i]) sb256.push_back(img256[i]);
                sb256.push_back(INSTR_END_B);
                img256.delete();
                done_m[1] = 1'b1;
            end
        end
    endtask

    task automatic send_byte(input int w, input logic [7:0] b, input bit bad_stop, input bit bad_par);
        logic [10:0] o;
        bit          hold_exp;
        string       tag;
        tag      = (w == 0) ? "dut8" : "dut256";
        hold_exp = !done_m[w];
        model_issue(w, b, !bad_stop && !bad_par);
        set_line(w, 1'b0);
        wait_cyc(CPB);
        o = outs(w);
        check({tag, "_hold_during_byte"}, 32'(o[2]), 32'(hold_exp));
        for (int i = 0; i < 8; i++) begin
            set_line(w, b[i]);
            wait_cyc(CPB);
        end
`ifdef LOADER_PARITY_EN
        set_line(w, (^b) ^ bad_par);
        wait_cyc(CPB);
`endif
        set_line(w, !bad_stop);
        wait_cyc(CPB);
        set_line(w, 1'b1);
        wait_cyc(4);
        o = outs(w);
        check({tag, "_frame_err"}, 32'(o[0]), 32'(ferr_m[w]));
    endtask

    task automatic finish_image(input int w, input int budget);
        logic [10:0] o;
        string       tag;
        tag = (w == 0) ? "dut8" : "dut256";
        wait_cyc(budget);
        o = outs(w);
        check({tag, "_stream_drained"}, (w == 0) ? sb8.size() : sb256.size(), 0);
        check({tag, "_hold_after_end"}, 32'(o[2]), 0);
        check({tag, "_load_done"}, 32'(o[1]), 1);
        check({tag, "_instr_idle_done"}, 32'(o[10:3]), 0);
    endtask

    task automatic do_reset(input string tag);
        logic [10:0] o;
        sys_reset = 1'b1;
        rx8       = 1'b1;
        rx256     = 1'b1;
        wait_cyc(2);
        for (int w = 0; w < 2; w++) begin
            o = outs(w);
            check({tag, "_rst_instr"}, 32'(o[10:3]), 0);
            check({tag, "_rst_hold"},  32'(o[2]), 0);
            check({tag, "_rst_done"},  32'(o[1]), 0);
            check({tag, "_rst_ferr"},  32'(o[0]), 0);
        end
        model_reset();
        wait_cyc(1);
        sys_reset = 1'b0;
        wait_cyc(3);
    endtask

    // Monitors: any non-idle instr_o opens a window of image+2 cycles, each popped from the scoreboard.
    always @(negedge sys_clk) begin
        if (sys_reset) begin
            win8 = 0;
        end else if (win8 > 0 || bus8.instr_o != 8'h00) begin
            if (sb8.size() == 0) begin
                check("dut8_unexpected_instr", 32'(bus8.instr_o), 0);
            end else begin
                if (win8 == 0) win8 = L8 + 2;
                check("dut8_instr_stream", 32'(bus8.instr_o), 32'(sb8.pop_front()));
                check("dut8_hold_in_burst", 32'(bus8.cpu_hold_o), 1);
                win8--;
            end
        end
    end

    always @(negedge sys_clk) begin
        if (sys_reset) begin
            win256 = 0;
        end else if (win256 > 0 || bus256.instr_o != 8'h00) begin
            if (sb256.size() == 0) begin
                check("dut256_unexpected_instr", 32'(bus256.instr_o), 0);
            end else begin
                if (win256 == 0) win256 = L256 + 2;
                check("dut256_instr_stream", 32'(bus256.instr_o), 32'(sb256.pop_front()));
                check("dut256_hold_in_burst", 32'(bus256.cpu_hold_o), 1);
                win256--;
            end
        end
    end

    initial begin
        logic [10:0] o;
        do_reset("por");

        // Short low glitch in idle must not start a byte.
        set_line(0, 1'b0);
        wait_cyc(4);
        set_line(0, 1'b1);
        wait_cyc(3 * CPB);
        o = outs(0);
        check("glitch_ferr", 32'(o[0]), 0);
        check("glitch_hold", 32'(o[2]), 0);
        check("glitch_done", 32'(o[1]), 0);

        for (int i = 1; i <= 8; i++) send_byte(0, 8'(i), 1'b0, 1'b0);
        finish_image(0, 40);
        send_byte(0, 8'h3C, 1'b0, 1'b0);
        o = outs(0);
        check("dut8_done_sticky", 32'(o[1]), 1);

        do_reset("bad_stop");
        for (int k = 0; k < 9; k++) begin
            send_byte(0, 8'($urandom), k == 3, 1'b0);
            if (k == 7) begin
                o = outs(0);
                check("dut8_not_done_before_8_good", 32'(o[1]), 0);
            end
        end
        finish_image(0, 40);

        do_reset("pre_mid");
        for (int k = 0; k < 5; k++) send_byte(0, 8'($urandom), 1'b0, 1'b0);
        do_reset("mid_recv");
        for (int k = 0; k < 8; k++) send_byte(0, 8'($urandom), 1'b0, 1'b0);
        finish_image(0, 40);

`ifdef LOADER_PARITY_EN
        do_reset("parity");
        send_byte(0, 8'hA5, 1'b0, 1'b1);
        send_byte(0, 8'hA5, 1'b0, 1'b0);
        for (int k = 0; k < 7; k++) send_byte(0, 8'($urandom), 1'b0, 1'b0);
        finish_image(0, 40);
`endif

        for (int k = 0; k < L256; k++) send_byte(1, 8'($urandom), 1'b0, 1'b0);
        finish_image(1, L256 + 60);
        send_byte(1, 8'($urandom), 1'b0, 1'b0);
        send_byte(1, 8'($urandom), 1'b1, 1'b0);
        send_byte(1, 8'($urandom), 1'b0, 1'b0);
        wait_cyc(20);
        o = outs(1);
        check("dut256_done_after_extra", 32'(o[1]), 1);
        check("dut256_instr_after_extra", 32'(o[10:3]), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        n_fail++;
        $display("FAIL watchdog: run still active at %0t, expected completion earlier", $time);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/instr_uart_loader.md
INSTR_UART_LOADER -- requirements
Module: instr_uart_loader

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 434, sys_clk cycles per UART bit (50 MHz / 115200).
REQ-002 Parameter: LOAD_BYTES, default `INSTR_MEM_NUM*4` (256), bytes per program image.
REQ-003 Port: sys_clk  input  1  rising-edge clock.
REQ-004 Port: sys_reset  input  1  asynchronous, active-high reset.
REQ-005 Port: uart_rx_i  input  1  asynchronous serial line, idle high.
REQ-006 Port: instr_o  output  8  byte stream to the instruction memory's instr_i.
REQ-007 Port: cpu_hold_o  output  1  holds the CPU core in reset while loading.
REQ-008 Port: load_done_o  output  1  high once a full image has been delivered.
REQ-009 Port: frame_err_o  output  1  sticky receive-error flag.

Function
REQ-010 uart_rx_i SHALL pass a 2-flop synchronizer before any use.
REQ-011 Receiver: a falling edge in idle starts a byte.
  - Start bit re-sampled at CLKS_PER_BIT/2; if high, return to idle with no error.
  - Data bits sampled LSB first at each full CLKS_PER_BIT interval, then the stop bit.
REQ-012 Stop bit sampled 0 SHALL:
  - discard the byte;
  - set frame_err_o;
  - leave the byte count unchanged.
REQ-013 Each valid byte SHALL be stored in an internal LOAD_BYTES x 8 buffer at the write pointer, which then increments.
REQ-014 Loader FSM states: IDLE, RECV, START, BURST, END, DONE.
REQ-015 IDLE->RECV on the first detected start bit.
REQ-016 RECV->START when the write pointer reaches LOAD_BYTES.
REQ-017 START SHALL drive instr_o=`INSTR_START` for exactly one cycle, then go to BURST.
REQ-018 BURST SHALL drive buffer[0..LOAD_BYTES-1] in reception order, one byte per consecutive cycle, with no gaps.
REQ-019 END SHALL drive instr_o=`INSTR_END` for one cycle, then go to DONE.
REQ-020 In all states other than START, BURST and END, instr_o SHALL be 8'h00.
REQ-021 cpu_hold_o SHALL be high from entry to RECV through the END cycle inclusive, and low in IDLE and DONE.
REQ-022 load_done_o SHALL go high on entry to DONE and stay high until reset.
REQ-023 In DONE, further UART bytes SHALL be received and discarded; the FSM does not leave DONE until reset.
REQ-024 UART bytes arriving during START/BURST/END SHALL be discarded; frame errors are still flagged.
REQ-025 The write pointer SHALL be LOAD_BYTES-bit-count wide with no wrap-around; reaching LOAD_BYTES ends RECV.

Reset
REQ-026 sys_reset SHALL asynchronously clear:
  - FSM to IDLE;
  - receiver to idle;
  - pointers to 0;
  - instr_o=8'h00, cpu_hold_o=0, load_done_o=0, frame_err_o=0.
  Buffer contents need not be cleared.
REQ-027 Reset mid-RECV or mid-BURST SHALL abandon the image; the next image restarts at byte 0.

Configuration
REQ-028 With LOADER_PARITY_EN defined:
  - the receiver expects an even-parity bit between bit 7 and the stop bit;
  - a parity mismatch is treated exactly as a frame error (REQ-012).
REQ-029 Without LOADER_PARITY_EN, the format is 8N1 and no parity logic exists.

Structure
REQ-030 `INSTR_START`, `INSTR_END` and `INSTR_MEM_NUM` SHALL come from the shared cpu_define file, not be redefined locally.
REQ-031 The serial receiver SHALL be a sub-module uart_rx with outputs rx_data[7:0], rx_valid (1-cycle pulse) and rx_err.
REQ-032 uart_rx SHALL be parameterized by CLKS_PER_BIT and honor LOADER_PARITY_EN.

Verification
REQ-033 The bench SHALL cover (CLKS_PER_BIT=16, LOAD_BYTES=8 unless stated):
  - Load: send 8 bytes 0x01..0x08 -> cpu_hold_o rises at the first start bit; instr_o = START, 01..08, END on 10 consecutive cycles; load_done_o=1; cpu_hold_o=0 after END.
  - Glitch: 4-cycle low pulse on uart_rx_i in IDLE -> no byte, frame_err_o=0, FSM stays IDLE.
  - Bad stop bit on byte 3 -> frame_err_o=1; byte discarded; the image completes only after 8 good bytes.
  - Reset: assert sys_reset after byte 5 -> all outputs 0; a fresh 8-byte stream loads correctly from index 0.
  - Default LOAD_BYTES=256, with bytes sent after DONE -> instr_o stays 00, load_done_o stays 1.
  - LOADER_PARITY_EN: byte 0xA5 with odd parity -> frame_err_o=1; with correct parity -> accepted.
